// File: rtl/inst_loader_pkg.sv
// inst_loader shared constants, core modes, ack bytes and loader states.
// Imported by the loader top and its byte packer.
package inst_loader_pkg;

  localparam int INST_SIZE = 8;

  localparam logic [2:0] MODE_STALL = 3'd0;
  localparam logic [2:0] MODE_LOAD  = 3'd1;
  localparam logic [2:0] MODE_EXEC  = 3'd2;

  localparam logic [7:0] ACK_OK  = 8'hAA;
  localparam logic [7:0] ACK_ERR = 8'h55;

  typedef enum logic [1:0] {
    HDR,
    DATA,
    ACK,
    DONE
  } loader_state_t;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Little-endian 4-byte assembler; o_word/o_word_valid are presented
// combinationally alongside the 4th byte so the caller can register them.
// Ports: i_clk, i_rst, i_en (byte strobe), i_byte,
//        o_word (assembled word), o_word_valid (4th-byte pulse).
module inst_loader_byte_packer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [23:0] r_shift;
  logic [1:0]  r_idx;

  // Only three bytes are stored; the 4th is merged on the fly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_en) begin
      r_shift <= {i_byte, r_shift[23:8]};
      r_idx   <= r_idx + 2'd1;
    end
  end

  assign o_word_valid = i_en && (r_idx == 2'd3);
  assign o_word       = {i_byte, r_shift};

endmodule

// File: rtl/inst_loader.sv
// Program loader: word-count header then LE words to the BRAM write port,
// finishing with a one-byte ack.
// Ports: i_clk, i_rst, i_mode, i_rx_data/i_rx_valid (byte stream),
//        o_bram_addr/o_bram_din/o_bram_we (BRAM write),
//        o_tx_data/o_tx_valid/i_tx_ready (ack), o_words_loaded, o_done, o_err.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = INST_SIZE
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [2:0]        i_mode,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [31:0]       o_bram_din,
  output logic              o_bram_we,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic [ADDR_W:0]   o_words_loaded,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [32:0] LP_CAP = 33'(1) << ADDR_W;

  loader_state_t r_state;
  loader_state_t w_next;

  logic              w_en;
  logic              w_word_valid;
  logic [31:0]       w_word;
  logic              w_hdr_done;
  logic              w_data_word;
  logic              w_n_zero;
  logic              w_n_big;
  logic              w_last;
  logic [ADDR_W:0]   w_words_inc;

  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_words;
  logic              r_bram_we;
  logic [31:0]       r_bram_din;
  logic [ADDR_W-1:0] r_bram_addr;
  logic [7:0]        r_ack;
  logic              r_err;

  // Bytes only count in LOAD mode and while a header or word is pending.
  assign w_en = i_rx_valid
             && (i_mode == MODE_LOAD)
             && ((r_state == HDR) || (r_state == DATA));

  inst_loader_byte_packer u_byte_packer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (w_en),
    .i_byte       (i_rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  assign w_hdr_done  = w_word_valid && (r_state == HDR);
  assign w_data_word = w_word_valid && (r_state == DATA);
  assign w_n_zero    = (w_word == 32'd0);
  assign w_n_big     = ({1'b0, w_word} > LP_CAP);
  assign w_words_inc = r_words + {{ADDR_W{1'b0}}, 1'b1};
  // Decided in the write cycle of the final word.
  assign w_last      = (r_state == DATA) && r_bram_we
                    && (w_words_inc == r_count);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= HDR;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      HDR: begin
        if (w_hdr_done) begin
          if (w_n_zero || w_n_big) w_next = ACK;
          else                     w_next = DATA;
        end
      end
      DATA: begin
        if (w_last) w_next = ACK;
      end
      ACK: begin
        if (i_tx_ready) w_next = DONE;
      end
      DONE:    w_next = DONE;
      default: w_next = HDR;
    endcase
  end

  always_comb begin
    o_tx_valid = 1'b0;
    o_done     = 1'b0;
    if (r_state == ACK)  o_tx_valid = 1'b1;
    if (r_state == DONE) o_done     = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count     <= '0;
      r_words     <= '0;
      r_bram_we   <= 1'b0;
      r_bram_din  <= '0;
      r_bram_addr <= '0;
      r_ack       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_bram_we <= w_data_word;
      if (w_data_word) begin
        r_bram_din  <= w_word;
        r_bram_addr <= r_words[ADDR_W-1:0];
      end
      if (r_bram_we) r_words <= w_words_inc;
      if (w_hdr_done) begin
        r_count <= w_word[ADDR_W:0];
        unique case (1'b1)
          w_n_zero: r_ack <= ACK_OK;
          w_n_big: begin
            r_err <= 1'b1;
            r_ack <= ACK_ERR;
          end
          default: ;
        endcase
      end
      if (w_last) r_ack <= ACK_OK;
    end
  end

  assign o_bram_we      = r_bram_we;
  assign o_bram_din     = r_bram_din;
  assign o_bram_addr    = r_bram_addr;
  assign o_tx_data      = r_ack;
  assign o_words_loaded = r_words;
  assign o_err          = r_err;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: randomized loads checked
// against a queue-based reference of expected writes and acks.
module tb_inst_loader;
  import inst_loader_pkg::*;

  localparam int AW  = INST_SIZE;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    mode = MODE_LOAD;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_din;
  logic          bram_we;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic [AW:0]   words_loaded;
  logic          done;
  logic          err;

  inst_loader #(.ADDR_W(AW)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_mode         (mode),
    .i_rx_data      (rx_data),
    .i_rx_valid     (rx_valid),
    .o_bram_addr    (bram_addr),
    .o_bram_din     (bram_din),
    .o_bram_we      (bram_we),
    .o_tx_data      (tx_data),
    .o_tx_valid     (tx_valid),
    .i_tx_ready     (tx_ready),
    .o_words_loaded (words_loaded),
    .o_done         (done),
    .o_err          (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int last_strobe = 0;

  logic [AW-1:0] obs_addr[$];
  logic [31:0]   obs_data[$];
  int            obs_cyc[$];
  int            exp_cyc[$];

  always @(negedge clk) begin
    if (bram_we) begin
      obs_addr.push_back(bram_addr);
      obs_data.push_back(bram_din);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
    exp_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    mode = MODE_LOAD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(posedge clk); #1;
    end
    rx_data = b;
    rx_valid = 1'b1;
    last_strobe = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // is_data: a BRAM write is expected one cycle after the 4th byte
  task automatic send_word(input logic [31:0] w, input int maxgap,
                           input bit is_data);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], $urandom_range(0, maxgap));
    if (is_data) exp_cyc.push_back(last_strobe + 1);
  endtask

  task automatic wait_tx(output bit ok, output int tc);
    ok = 1'b0;
    tc = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx_valid) begin
        ok = 1'b1;
        tc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [2:0] junk_mode();
    logic [2:0] m;
    m = 3'($urandom_range(0, 6));
    if (m >= MODE_LOAD) m = m + 3'd1;
    return m;
  endfunction

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bram_we, bram_addr, bram_din} !== '0)
      $display("FAIL reset_bram got we=%b a=%h d=%h exp 0",
               bram_we, bram_addr, bram_din);
    else n_pass++;
    n_checks++;
    if ({tx_valid, tx_data} !== '0)
      $display("FAIL reset_tx got v=%b d=%h exp 0", tx_valid, tx_data);
    else n_pass++;
    n_checks++;
    if ({words_loaded, done, err} !== '0)
      $display("FAIL reset_status got wl=%0d done=%b err=%b exp 0",
               words_loaded, done, err);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [31:0] w[3];
    bit ok;
    int tc;
    w[0] = 32'h1234_5678;
    w[1] = 32'hDEAD_BEEF;
    w[2] = 32'h0000_0001;
    do_reset();
    tx_ready = 1'b1;
    send_word(32'd3, 1, 1'b0);
    for (int i = 0; i < 3; i++) send_word(w[i], 2, 1'b1);
    wait_tx(ok, tc);
    n_checks++;
    if (!ok) $display("FAIL dir_tx_timeout got none exp tx_valid");
    else n_pass++;
    n_checks++;
    if (obs_data.size() != 3)
      $display("FAIL dir_count got %0d exp 3", obs_data.size());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= obs_data.size())
        $display("FAIL dir_write%0d got none exp %h", i, w[i]);
      else if (obs_addr[i] !== AW'(i) || obs_data[i] !== w[i])
        $display("FAIL dir_write%0d got a=%0d d=%h exp a=%0d d=%h",
                 i, obs_addr[i], obs_data[i], i, w[i]);
      else n_pass++;
      n_checks++;
      if (i >= obs_cyc.size() || obs_cyc[i] != exp_cyc[i])
        $display("FAIL dir_lat%0d got cyc %0d exp cyc %0d", i,
                 (i < obs_cyc.size()) ? obs_cyc[i] : -1, exp_cyc[i]);
      else n_pass++;
    end
    n_checks++;
    if (obs_cyc.size() == 0 || tc != obs_cyc[obs_cyc.size()-1] + 1)
      $display("FAIL dir_tx_rise got cyc %0d exp after last we", tc);
    else n_pass++;
    n_checks++;
    if (tx_data !== ACK_OK)
      $display("FAIL dir_ack got %h exp %h", tx_data, ACK_OK);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({done, tx_valid, err, words_loaded} !== {1'b1, 1'b0, 1'b0, (AW+1)'(3)})
      $display("FAIL dir_done got done=%b v=%b err=%b wl=%0d exp 1 0 0 3",
               done, tx_valid, err, words_loaded);
    else n_pass++;
    send_word($urandom, 0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (obs_data.size() != 3 || words_loaded !== (AW+1)'(3) || !done)
      $display("FAIL dir_after_done got writes=%0d wl=%0d exp 3 3",
               obs_data.size(), words_loaded);
    else n_pass++;
  endtask

  task automatic test_random_load();
    logic [31:0] words[$];
    bit ok;
    int tc, n, bad;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      words.delete();
      n = $urandom_range(1, 12);
      send_word(32'(n), 2, 1'b0);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          mode = junk_mode();
          send_byte(8'($urandom), 0);
          mode = MODE_LOAD;
        end
        words.push_back($urandom);
        send_word(words[i], 2, 1'b1);
      end
      wait_tx(ok, tc);
      n_checks++;
      if (obs_data.size() != n)
        $display("FAIL rnd_count got %0d exp %0d", obs_data.size(), n);
      else n_pass++;
      bad = 0;
      for (int i = 0; i < n && i < obs_data.size(); i++)
        if (obs_addr[i] !== AW'(i) || obs_data[i] !== words[i]
            || obs_cyc[i] != exp_cyc[i]) bad++;
      n_checks++;
      if (bad != 0) $display("FAIL rnd_writes got %0d bad exp 0", bad);
      else n_pass++;
      n_checks++;
      if (!ok || tx_data !== ACK_OK)
        $display("FAIL rnd_ack got ok=%b d=%h exp %h", ok, tx_data, ACK_OK);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (!done || words_loaded !== (AW+1)'(n))
        $display("FAIL rnd_done got done=%b wl=%0d exp 1 %0d",
                 done, words_loaded, n);
      else n_pass++;
    end
  endtask

  task automatic test_zero();
    bit ok;
    int tc;
    do_reset();
    send_word(32'd0, 1, 1'b0);
    wait_tx(ok, tc);
    n_checks++;
    if (!ok || tx_data !== ACK_OK)
      $display("FAIL zero_ack got ok=%b d=%h exp %h", ok, tx_data, ACK_OK);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (!done || err || obs_data.size() != 0)
      $display("FAIL zero_done got done=%b err=%b writes=%0d exp 1 0 0",
               done, err, obs_data.size());
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [31:0] hdr[2];
    bit ok;
    int tc;
    hdr[0] = 32'(CAP + 1);
    hdr[1] = $urandom | 32'h0100_0000;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      send_word(hdr[k], 1, 1'b0);
      wait_tx(ok, tc);
      n_checks++;
      if (!ok || tx_data !== ACK_ERR || !err)
        $display("FAIL ovf_ack%0d got ok=%b d=%h err=%b exp %h 1",
                 k, ok, tx_data, err, ACK_ERR);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (!done || !err || obs_data.size() != 0)
        $display("FAIL ovf_done%0d got done=%b err=%b writes=%0d exp 1 1 0",
                 k, done, err, obs_data.size());
      else n_pass++;
    end
  endtask

  task automatic test_ack_hold();
    do_reset();
    tx_ready = 1'b0;
    send_word(32'd0, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({tx_valid, tx_data, done} !== {1'b1, ACK_OK, 1'b0})
        $display("FAIL hold_c%0d got v=%b d=%h done=%b exp 1 %h 0",
                 i, tx_valid, tx_data, done, ACK_OK);
      else n_pass++;
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (!done || tx_valid)
      $display("FAIL hold_done got done=%b v=%b exp 1 0", done, tx_valid);
    else n_pass++;
  endtask

  task automatic test_mode_stall();
    logic [31:0] w;
    bit ok;
    int tc;
    w = $urandom;
    do_reset();
    send_word(32'd1, 1, 1'b0);
    send_byte(w[7:0], 1);
    send_byte(w[15:8], 0);
    mode = MODE_STALL;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1);
    mode = MODE_LOAD;
    send_byte(w[23:16], 2);
    send_byte(w[31:24], 0);
    exp_cyc.push_back(last_strobe + 1);
    wait_tx(ok, tc);
    n_checks++;
    if (obs_data.size() != 1 || obs_data[0] !== w || obs_addr[0] !== '0
        || obs_cyc[0] != exp_cyc[0])
      $display("FAIL stall_word got n=%0d d=%h exp 1 %h", obs_data.size(),
               (obs_data.size() > 0) ? obs_data[0] : 32'hx, w);
    else n_pass++;
    n_checks++;
    if (!ok || tx_data !== ACK_OK)
      $display("FAIL stall_ack got ok=%b d=%h exp %h", ok, tx_data, ACK_OK);
    else n_pass++;
  endtask

  task automatic test_rst_mid();
    logic [31:0] w;
    bit ok;
    int tc;
    w = $urandom;
    do_reset();
    send_word(32'd2, 1, 1'b0);
    send_byte(8'($urandom), 0);
    send_byte(8'($urandom), 1);
    n_checks++;
    if (obs_data.size() != 0)
      $display("FAIL rstmid_early got %0d writes exp 0", obs_data.size());
    else n_pass++;
    do_reset();
    n_checks++;
    if ({bram_we, bram_din, tx_valid, words_loaded, done, err} !== '0)
      $display("FAIL rstmid_zero got we=%b d=%h wl=%0d exp 0",
               bram_we, bram_din, words_loaded);
    else n_pass++;
    send_word(32'd1, 1, 1'b0);
    send_word(w, 1, 1'b1);
    wait_tx(ok, tc);
    n_checks++;
    if (obs_data.size() != 1 || obs_data[0] !== w || obs_addr[0] !== '0)
      $display("FAIL rstmid_write got n=%0d d=%h exp 1 %h", obs_data.size(),
               (obs_data.size() > 0) ? obs_data[0] : 32'hx, w);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (!done || words_loaded !== (AW+1)'(1))
      $display("FAIL rstmid_done got done=%b wl=%0d exp 1 1",
               done, words_loaded);
    else n_pass++;
  endtask

  task automatic test_full();
    logic [31:0] words[$];
    bit ok;
    int tc, bad;
    do_reset();
    send_word(32'(CAP), 0, 1'b0);
    for (int i = 0; i < CAP; i++) begin
      words.push_back($urandom);
      send_word(words[i], 0, 1'b1);
    end
    wait_tx(ok, tc);
    bad = 0;
    for (int i = 0; i < CAP && i < obs_data.size(); i++)
      if (obs_addr[i] !== AW'(i) || obs_data[i] !== words[i]) bad++;
    n_checks++;
    if (obs_data.size() != CAP || bad != 0)
      $display("FAIL full_writes got n=%0d bad=%0d exp %0d 0",
               obs_data.size(), bad, CAP);
    else n_pass++;
    n_checks++;
    if (!ok || tx_data !== ACK_OK || err)
      $display("FAIL full_ack got ok=%b d=%h err=%b exp %h 0",
               ok, tx_data, err, ACK_OK);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (!done || words_loaded !== (AW+1)'(CAP))
      $display("FAIL full_done got done=%b wl=%0d exp 1 %0d",
               done, words_loaded, CAP);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_load();
    test_zero();
    test_overflow();
    test_ack_hold();
    test_mode_stall();
    test_rst_mid();
    test_full();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
# inst_loader

Program loader that fills the instruction BRAM from a byte stream, such as the UART receiver output, before execution begins. It receives a 4-byte word-count header, then assembles little-endian 32-bit instruction words and writes them to the BRAM write port at consecutive addresses. On completion it returns a one-byte acknowledge to the host. It sits between the UART receiver/transmitter and the BRAM write port, and runs only while the core is in LOAD mode.

## Interface
- ADDR_W, default INST_SIZE (shared package): BRAM word-address width; capacity 2**ADDR_W words
- clk  in  1  system clock, single clock domain
- rst  in  1  reset, synchronous, active-high
- mode  in  3  core mode; loader active only when mode == MODE_LOAD (1)
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe qualifying rx_data; no backpressure
- bram_addr  out  ADDR_W  BRAM write word address
- bram_din  out  32  BRAM write data
- bram_we  out  1  BRAM write enable, one-cycle pulse per word
- tx_data  out  8  acknowledge byte
- tx_valid  out  1  acknowledge valid; held until tx_ready
- tx_ready  in  1  transmitter accepts tx_data when tx_valid && tx_ready
- words_loaded  out  ADDR_W+1  count of words written so far
- done  out  1  load finished; sticky until rst
- err  out  1  header count exceeded capacity; sticky until rst

## Operation
- Reset values: state HDR, every output 0, byte index 0, shift register 0.
- rx_valid is ignored when mode != MODE_LOAD. State, byte index and partial word are retained while mode is not LOAD, so loading resumes when LOAD returns.
- HDR: collect 4 bytes, little-endian (first byte = bits 7:0), into count N (32 bits).
  - On the 4th byte: N == 0 -> ACK with ack byte 0xAA.
  - N > 2**ADDR_W -> err=1, ACK with ack byte 0x55, no writes.
  - Otherwise -> DATA.
- DATA: collect 4 bytes little-endian into a word. On the 4th byte:
  - Next cycle: bram_we=1, bram_din=word, bram_addr=words_loaded[ADDR_W-1:0].
  - words_loaded increments in that same cycle.
  - When words_loaded reaches N -> ACK with 0xAA.
- ACK: tx_valid=1 with the ack byte. Leave on tx_valid && tx_ready -> DONE, tx_valid drops the next cycle.
- DONE: done=1. All rx bytes are ignored until rst.
- Byte index wraps 3->0. A byte arriving the same cycle as bram_we is captured normally; write and capture do not conflict.
- rst mid-load: everything returns to reset values and the next byte is treated as header byte 0. BRAM contents are not cleared.
- N == 2**ADDR_W is legal. bram_addr wraps to 0 only after the final write, and words_loaded == 2**ADDR_W fits in ADDR_W+1 bits.

## Timing
- Latency from the 4th data byte's rx_valid to bram_we is exactly 1 cycle. bram_addr and bram_din are valid in the bram_we cycle; bram_we is never asserted on consecutive words faster than 1 per 4 rx strobes.
- Transition to ACK happens in the bram_we cycle of the last word; tx_valid rises the following cycle.
- done rises the cycle after the tx handshake.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package (constant): INST_SIZE, MODE_STALL/MODE_LOAD/MODE_EXEC, ACK_OK=8'hAA, ACK_ERR=8'h55, state enum loader_state_t {HDR, DATA, ACK, DONE}.
- One sub-module: byte_packer, a 4-byte little-endian shift/assemble stage with a word_valid pulse. It is reused for both header and data.

## Test plan
- N=3, then bytes 78 56 34 12, EF BE AD DE, 01 00 00 00 in LOAD -> writes addr0=0x12345678, addr1=0xDEADBEEF, addr2=0x00000001, each bram_we 1 cycle after the 4th byte. Then tx 0xAA, done=1, words_loaded=3.
- N=0 header -> no bram_we, tx 0xAA, done=1.
- N=2**ADDR_W+1 header -> err=1, tx 0x55, no bram_we, done=1 after handshake.
- tx_ready held low 10 cycles during ACK -> tx_valid and tx_data stable for all 10 cycles; done stays 0 until the handshake.
- Mode switches to STALL after 2 bytes of a word; 3 strobes are sent (ignored); back to LOAD, then 2 bytes -> the word assembles from the 4 LOAD-mode bytes only.
- rst asserted after the 6th byte of a load -> outputs 0; a fresh header N=1 plus one word writes addr0 correctly.
